// File: rtl/thdb_ad_trap_analyzer_pkg.sv
// Shared definitions for the ADC trapezoid analyzer.
// FSM encoding, default thresholds and datapath widths.
package thdb_ad_trap_analyzer_pkg;

    localparam int DEF_DATA_W = 14;
    localparam int DEF_CNT_W  = 16;

    localparam logic [DEF_DATA_W-1:0] DEF_LO_TH = 14'h0400;
    localparam logic [DEF_DATA_W-1:0] DEF_HI_TH = 14'h3C00;

    localparam int                   DEF_MIN_BASE = 8;
    localparam logic [DEF_CNT_W-1:0] DEF_TIMEOUT  = 16'hF000;

    typedef enum logic [2:0] {
        S_WAIT,
        S_ARM,
        S_RISE,
        S_TOP,
        S_FALL,
        S_DONE
    } state_t;

endpackage

// File: rtl/thdb_ad_trap_analyzer_sat_counter.sv
// Saturating up-counter used for baseline and phase durations.
// Clear together with enable restarts the count at one.
module thdb_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             CLOCK_100,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    // Count enabled samples, holding at all-ones instead of wrapping
    always_ff @(posedge CLOCK_100 or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= i_en ? CNT_W'(1) : '0;
        end else if (i_en && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/thdb_ad_trap_analyzer.sv
// ADC-side trapezoid pulse analyzer: peak height plus rise,
// flat-top and fall durations, one handshaked record per pulse.
module thdb_ad_trap_analyzer
    import thdb_ad_trap_analyzer_pkg::*;
#(
    parameter int                DATA_W   = DEF_DATA_W,
    parameter int                CNT_W    = DEF_CNT_W,
    parameter logic [DATA_W-1:0] LO_TH    = DEF_LO_TH,
    parameter logic [DATA_W-1:0] HI_TH    = DEF_HI_TH,
    parameter int                MIN_BASE = DEF_MIN_BASE,
    parameter logic [CNT_W-1:0]  TIMEOUT  = DEF_TIMEOUT
) (
    input  logic              CLOCK_100,
    input  logic              rst_n,
    output logic              AD_CLK,
    input  logic [DATA_W-1:0] AD_DATA,
    input  logic              AD_OTR,
    output logic              meas_valid,
    input  logic              meas_ready,
    output logic [DATA_W-1:0] peak,
    output logic [CNT_W-1:0]  rise_cyc,
    output logic [CNT_W-1:0]  top_cyc,
    output logic [CNT_W-1:0]  fall_cyc,
    output logic              otr_seen,
    output logic              overrun,
    output logic              timeout_err
);

    localparam logic [CNT_W-1:0] BASE_LAST = CNT_W'(MIN_BASE - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = TIMEOUT - CNT_W'(1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_s_data;
    logic              r_s_otr;
    logic              w_lo;
    logic              w_hi;
    logic              w_mid;

    logic              w_base_clr, w_base_en;
    logic              w_rise_clr, w_rise_en;
    logic              w_top_clr,  w_top_en;
    logic              w_fall_clr, w_fall_en;
    logic [CNT_W-1:0]  w_base_cnt;
    logic [CNT_W-1:0]  w_rise_cnt;
    logic [CNT_W-1:0]  w_top_cnt;
    logic [CNT_W-1:0]  w_fall_cnt;

    logic              w_acc_clr;
    logic              w_acc_upd;
    logic              w_done;
    logic              w_tmo;
    logic              w_hs;
    logic [DATA_W-1:0] r_peak_acc;
    logic [DATA_W-1:0] w_peak_nxt;
    logic              r_otr_acc;
    logic              w_otr_nxt;

    logic              r_valid;
    logic [DATA_W-1:0] r_peak;
    logic [CNT_W-1:0]  r_rise;
    logic [CNT_W-1:0]  r_top;
    logic [CNT_W-1:0]  r_fall;
    logic              r_otr;
    logic              r_overrun;
    logic              r_timeout;

    assign AD_CLK = CLOCK_100;
    assign w_lo   = r_s_data < LO_TH;
    assign w_hi   = r_s_data >= HI_TH;
    assign w_mid  = !w_lo && !w_hi;
    assign w_hs   = r_valid && meas_ready;

    // Register the ADC word and range flag once before classification
    always_ff @(posedge CLOCK_100 or negedge rst_n) begin
        if (!rst_n) begin
            r_s_data <= '0;
            r_s_otr  <= 1'b0;
        end else begin
            r_s_data <= AD_DATA;
            r_s_otr  <= AD_OTR;
        end
    end

    thdb_sat_counter #(.CNT_W(CNT_W)) u_base (
        .CLOCK_100 (CLOCK_100),
        .rst_n     (rst_n),
        .i_clr     (w_base_clr),
        .i_en      (w_base_en),
        .o_cnt     (w_base_cnt)
    );

    thdb_sat_counter #(.CNT_W(CNT_W)) u_rise (
        .CLOCK_100 (CLOCK_100),
        .rst_n     (rst_n),
        .i_clr     (w_rise_clr),
        .i_en      (w_rise_en),
        .o_cnt     (w_rise_cnt)
    );

    thdb_sat_counter #(.CNT_W(CNT_W)) u_top (
        .CLOCK_100 (CLOCK_100),
        .rst_n     (rst_n),
        .i_clr     (w_top_clr),
        .i_en      (w_top_en),
        .o_cnt     (w_top_cnt)
    );

    thdb_sat_counter #(.CNT_W(CNT_W)) u_fall (
        .CLOCK_100 (CLOCK_100),
        .rst_n     (rst_n),
        .i_clr     (w_fall_clr),
        .i_en      (w_fall_en),
        .o_cnt     (w_fall_cnt)
    );

    // Pulse state register
    always_ff @(posedge CLOCK_100 or negedge rst_n) begin
        if (!rst_n) r_state <= S_WAIT;
        else        r_state <= w_state_nxt;
    end

    // Next state and counter controls; every sample counts in its own class
    always_comb begin
        w_state_nxt = r_state;
        w_base_clr  = 1'b0;
        w_base_en   = 1'b0;
        w_rise_clr  = 1'b0;
        w_rise_en   = 1'b0;
        w_top_clr   = 1'b0;
        w_top_en    = 1'b0;
        w_fall_clr  = 1'b0;
        w_fall_en   = 1'b0;
        w_acc_clr   = 1'b0;
        w_acc_upd   = 1'b0;
        w_done      = 1'b0;
        w_tmo       = 1'b0;
        unique case (r_state)
            S_WAIT: begin
                if (w_lo) begin
                    w_base_en = 1'b1;
                    if (w_base_cnt == BASE_LAST) w_state_nxt = S_ARM;
                end else begin
                    w_base_clr = 1'b1;
                end
            end
            S_ARM: begin
                w_rise_clr = 1'b1;
                w_top_clr  = 1'b1;
                w_fall_clr = 1'b1;
                w_acc_clr  = 1'b1;
                w_acc_upd  = !w_lo;
                if (w_hi) begin
                    w_top_en    = 1'b1;
                    w_state_nxt = S_TOP;
                end else if (w_mid) begin
                    w_rise_en   = 1'b1;
                    w_state_nxt = S_RISE;
                end
            end
            S_RISE: begin
                w_acc_upd = !w_lo;
                if (w_hi) begin
                    w_top_en    = 1'b1;
                    w_state_nxt = S_TOP;
                end else if (w_mid) begin
                    w_rise_en = 1'b1;
                end else begin
                    w_base_clr  = 1'b1;
                    w_base_en   = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_TOP: begin
                w_acc_upd = !w_lo;
                if (w_hi) begin
                    w_top_en = 1'b1;
                end else if (w_mid) begin
                    w_fall_en   = 1'b1;
                    w_state_nxt = S_FALL;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            S_FALL: begin
                w_acc_upd = !w_lo;
                if (w_hi) begin
                    w_top_en    = 1'b1;
                    w_state_nxt = S_TOP;
                end else if (w_mid) begin
                    w_fall_en = 1'b1;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_base_clr  = 1'b1;
                w_base_en   = 1'b1;
                w_state_nxt = S_WAIT;
            end
            default: w_state_nxt = S_WAIT;
        endcase
        if ((w_rise_en && (w_rise_cnt == TMO_LAST)) ||
            (w_top_en  && (w_top_cnt  == TMO_LAST)) ||
            (w_fall_en && (w_fall_cnt == TMO_LAST))) begin
            w_tmo       = 1'b1;
            w_base_clr  = 1'b1;
            w_base_en   = 1'b0;
            w_state_nxt = S_WAIT;
        end
    end

    // Running peak and out-of-range flag for the pulse in flight
    always_comb begin
        w_peak_nxt = w_acc_clr ? '0 : r_peak_acc;
        w_otr_nxt  = w_acc_clr ? 1'b0 : r_otr_acc;
        if (w_acc_upd) begin
            if (r_s_data > w_peak_nxt) w_peak_nxt = r_s_data;
            w_otr_nxt = w_otr_nxt | r_s_otr;
        end
    end

    // Accumulator registers
    always_ff @(posedge CLOCK_100 or negedge rst_n) begin
        if (!rst_n) begin
            r_peak_acc <= '0;
            r_otr_acc  <= 1'b0;
        end else begin
            r_peak_acc <= w_peak_nxt;
            r_otr_acc  <= w_otr_nxt;
        end
    end

    // Output record: load on completion when the slot is free or draining
    always_ff @(posedge CLOCK_100 or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_peak  <= '0;
            r_rise  <= '0;
            r_top   <= '0;
            r_fall  <= '0;
            r_otr   <= 1'b0;
        end else if (w_done && (!r_valid || meas_ready)) begin
            r_valid <= 1'b1;
            r_peak  <= r_peak_acc;
            r_rise  <= w_rise_cnt;
            r_top   <= w_top_cnt;
            r_fall  <= w_fall_cnt;
            r_otr   <= r_otr_acc;
        end else if (w_hs) begin
            r_valid <= 1'b0;
        end
    end

    // Sticky error flags, cleared when a record is accepted
    always_ff @(posedge CLOCK_100 or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            if (w_hs) begin
                r_overrun <= 1'b0;
                r_timeout <= 1'b0;
            end
            if (w_done && r_valid && !meas_ready) r_overrun <= 1'b1;
            if (w_tmo) r_timeout <= 1'b1;
        end
    end

    assign meas_valid  = r_valid;
    assign peak        = r_peak;
    assign rise_cyc    = r_rise;
    assign top_cyc     = r_top;
    assign fall_cyc    = r_fall;
    assign otr_seen    = r_otr;
    assign overrun     = r_overrun;
    assign timeout_err = r_timeout;

endmodule

// File: tb/tb_thdb_ad_trap_analyzer.sv
// Self-checking bench for the ADC trapezoid analyzer.
// Expected records are queued with stimulus and matched on handshake.
module tb_thdb_ad_trap_analyzer;
    import thdb_ad_trap_analyzer_pkg::*;

    typedef struct packed {
        logic        otr;
        logic [15:0] fall;
        logic [15:0] top;
        logic [15:0] rise;
        logic [13:0] peak;
    } rec_t;

    logic        CLOCK_100;
    logic        rst_n;
    logic        AD_CLK;
    logic [13:0] AD_DATA;
    logic        AD_OTR;
    logic        meas_valid;
    logic        meas_ready;
    logic [13:0] peak;
    logic [15:0] rise_cyc;
    logic [15:0] top_cyc;
    logic [15:0] fall_cyc;
    logic        otr_seen;
    logic        overrun;
    logic        timeout_err;

    int   checks;
    int   failures;
    int   n_valid;
    rec_t exp_q[$];
    rec_t got_q[$];

    thdb_ad_trap_analyzer dut (
        .CLOCK_100   (CLOCK_100),
        .rst_n       (rst_n),
        .AD_CLK      (AD_CLK),
        .AD_DATA     (AD_DATA),
        .AD_OTR      (AD_OTR),
        .meas_valid  (meas_valid),
        .meas_ready  (meas_ready),
        .peak        (peak),
        .rise_cyc    (rise_cyc),
        .top_cyc     (top_cyc),
        .fall_cyc    (fall_cyc),
        .otr_seen    (otr_seen),
        .overrun     (overrun),
        .timeout_err (timeout_err)
    );

    initial begin
        CLOCK_100 = 1'b0;
        forever #5 CLOCK_100 = ~CLOCK_100;
    end

    // Capture every accepted record away from the active edge
    always @(negedge CLOCK_100) begin
        if (rst_n && meas_valid) begin
            n_valid++;
            if (meas_ready)
                got_q.push_back({otr_seen, fall_cyc, top_cyc, rise_cyc, peak});
        end
    end

    task automatic step(input logic [13:0] d, input logic o);
        AD_DATA = d;
        AD_OTR  = o;
        @(posedge CLOCK_100);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(14'h0000, 1'b0);
    endtask

    task automatic pulse(input int start, input int hold,
                         input int stop, input int otr_at);
        for (int v = start; v <= 'h3E00; v += 'h200) step(14'(v), 1'b0);
        for (int i = 0; i < hold; i++) step(14'h3E00, i == otr_at);
        for (int v = 'h3C00; v >= stop; v -= 'h200) step(14'(v), 1'b0);
    endtask

    task automatic push_exp(input int hold, input logic o);
        exp_q.push_back({o, 16'd28, 16'(hold + 3), 16'd28, 14'h3E00});
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge CLOCK_100);
        #1;
        checks++;
        if ({meas_valid, peak, rise_cyc, top_cyc, fall_cyc,
             otr_seen, overrun, timeout_err} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got v=%b pk=%h r=%h t=%h f=%h o=%b ov=%b to=%b want all 0",
                     meas_valid, peak, rise_cyc, top_cyc, fall_cyc,
                     otr_seen, overrun, timeout_err);
        end
        checks++;
        if (dut.r_state !== S_WAIT) begin
            failures++;
            $display("FAIL reset_state: got %0d want %0d", dut.r_state, S_WAIT);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single_pulse;
        rec_t e, g;
        meas_ready = 1'b1;
        idle(20);
        push_exp(100, 1'b0);
        pulse(0, 100, 0, -1);
        idle(40);
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL single_count: got %0d want %0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL single_rec: got %h want %h", g, e);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_overrun;
        rec_t e, g, held;
        meas_ready = 1'b0;
        push_exp(100, 1'b0);
        pulse(0, 100, 0, -1);
        idle(40);
        pulse(0, 100, 0, -1);
        idle(40);
        checks++;
        if (meas_valid !== 1'b1 || overrun !== 1'b1) begin
            failures++;
            $display("FAIL overrun_set: got v=%b ov=%b want v=1 ov=1", meas_valid, overrun);
        end
        held = {otr_seen, fall_cyc, top_cyc, rise_cyc, peak};
        checks++;
        if (held !== exp_q[0]) begin
            failures++;
            $display("FAIL overrun_held: got %h want %h", held, exp_q[0]);
        end
        meas_ready = 1'b1;
        step(14'h0000, 1'b0);
        checks++;
        if (meas_valid !== 1'b0 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL overrun_clear: got v=%b ov=%b want v=0 ov=0", meas_valid, overrun);
        end
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL overrun_count: got %0d want %0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL overrun_rec: got %h want %h", g, e);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_runt;
        int nv0;
        meas_ready = 1'b1;
        idle(20);
        nv0 = n_valid;
        for (int v = 0; v <= 'h2000; v += 'h200) step(14'(v), 1'b0);
        for (int v = 'h1E00; v >= 0; v -= 'h200) step(14'(v), 1'b0);
        checks++;
        if (dut.r_state !== S_WAIT) begin
            failures++;
            $display("FAIL runt_state: got %0d want %0d", dut.r_state, S_WAIT);
        end
        idle(20);
        checks++;
        if (n_valid !== nv0) begin
            failures++;
            $display("FAIL runt_valid: got %0d valid cycles want 0", n_valid - nv0);
        end
        got_q.delete();
    endtask

    task automatic test_arming;
        rec_t e, g;
        meas_ready = 1'b1;
        step(14'h1000, 1'b0);
        idle(4);
        pulse('h400, 100, 'h400, -1);
        idle(8);
        push_exp(100, 1'b0);
        pulse('h400, 100, 'h400, -1);
        idle(20);
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL arm_count: got %0d want %0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL arm_rec: got %h want %h", g, e);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_timeout;
        rec_t e, g;
        int   nv0;
        meas_ready = 1'b1;
        idle(20);
        nv0 = n_valid;
        pulse(0, 'hF000, 0, -1);
        idle(40);
        checks++;
        if (timeout_err !== 1'b1) begin
            failures++;
            $display("FAIL tmo_flag: got %b want 1", timeout_err);
        end
        checks++;
        if (n_valid !== nv0) begin
            failures++;
            $display("FAIL tmo_norec: got %0d valid cycles want 0", n_valid - nv0);
        end
        got_q.delete();
        push_exp(100, 1'b0);
        pulse(0, 100, 0, -1);
        idle(40);
        checks++;
        if (timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL tmo_clear: got %b want 0", timeout_err);
        end
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL tmo_count: got %0d want %0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL tmo_rec: got %h want %h", g, e);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_reset_mid_pulse;
        rec_t e, g;
        meas_ready = 1'b0;
        idle(20);
        pulse(0, 100, 0, -1);
        idle(40);
        checks++;
        if (meas_valid !== 1'b1) begin
            failures++;
            $display("FAIL midrst_pending: got %b want 1", meas_valid);
        end
        for (int v = 0; v <= 'h3E00; v += 'h200) step(14'(v), 1'b0);
        repeat (10) step(14'h3E00, 1'b0);
        checks++;
        if (dut.r_state !== S_TOP) begin
            failures++;
            $display("FAIL midrst_intop: got %0d want %0d", dut.r_state, S_TOP);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({meas_valid, peak, rise_cyc, top_cyc, fall_cyc,
             otr_seen, overrun, timeout_err} !== '0) begin
            failures++;
            $display("FAIL midrst_outputs: got v=%b pk=%h r=%h t=%h f=%h o=%b ov=%b to=%b want all 0",
                     meas_valid, peak, rise_cyc, top_cyc, fall_cyc,
                     otr_seen, overrun, timeout_err);
        end
        @(posedge CLOCK_100);
        #1;
        rst_n = 1'b1;
        meas_ready = 1'b1;
        got_q.delete();
        idle(10);
        push_exp(100, 1'b1);
        pulse(0, 100, 0, 50);
        idle(40);
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL midrst_count: got %0d want %0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL midrst_rec: got %h want %h", g, e);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        n_valid    = 0;
        AD_DATA    = 14'h0000;
        AD_OTR     = 1'b0;
        meas_ready = 1'b0;
        test_reset();
        test_single_pulse();
        test_overrun();
        test_runt();
        test_arming();
        test_timeout();
        test_reset_mid_pulse();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
